// File: rtl/fb_scanout.sv
// fb_scanout: raster timing generator and upscaling framebuffer scanout.
// Produces RGB565 video with hsync/vsync/de, one pixel of output latency,
// fetching one framebuffer texel per in-window pixel tick.
module fb_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FB_WIDTH   = 64,
  parameter int unsigned FB_HEIGHT  = 64,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned X_OFFSET   = 192,
  parameter int unsigned Y_OFFSET   = 112
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         scan_enable,
  input  logic [15:0]                  border_color,
  output logic [$clog2(FB_WIDTH)-1:0]  fb_read_x,
  output logic [$clog2(FB_HEIGHT)-1:0] fb_read_y,
  output logic                         fb_read_en,
  input  logic [15:0]                  fb_read_data,
  input  logic                         fb_read_valid,
  output logic [15:0]                  vid_rgb,
  output logic                         vid_hsync,
  output logic                         vid_vsync,
  output logic                         vid_de,
  output logic                         frame_start,
  output logic                         underrun,
  input  logic                         underrun_clear
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned XW      = $clog2(FB_WIDTH);
  localparam int unsigned YW      = $clog2(FB_HEIGHT);
  localparam int unsigned WIN_W   = FB_WIDTH << SCALE_LOG2;
  localparam int unsigned WIN_H   = FB_HEIGHT << SCALE_LOG2;

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  int unsigned   hu, vu;
  logic          tick;
  logic          active, hs_on, vs_on, in_win, at_origin;
  logic [HW-1:0] dx;
  logic [VW-1:0] dy;

  // Decoded attributes of the pixel to be presented at the next tick.
  logic          p_active, p_hs, p_vs, p_win, p_origin;
  logic          pending;
  logic [15:0]   hold;
  logic [15:0]   pix;
  logic          miss;

  // Region decode of the current raster position and fetch address.
  always_comb begin
    hu        = 32'(h_cnt);
    vu        = 32'(v_cnt);
    tick      = (div_cnt == '0);
    active    = (hu < H_ACTIVE) && (vu < V_ACTIVE);
    hs_on     = (hu >= H_ACTIVE + H_FP) && (hu < H_ACTIVE + H_FP + H_SYNC);
    vs_on     = (vu >= V_ACTIVE + V_FP) && (vu < V_ACTIVE + V_FP + V_SYNC);
    in_win    = active && (hu >= X_OFFSET) && (hu < X_OFFSET + WIN_W)
                       && (vu >= Y_OFFSET) && (vu < Y_OFFSET + WIN_H);
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    dx        = h_cnt - HW'(X_OFFSET);
    dy        = v_cnt - VW'(Y_OFFSET);
    // Read data arriving in the very cycle of the next tick (CLK_DIV=2) is
    // forwarded straight to the output rather than missed.
    pix       = (pending && fb_read_valid) ? fb_read_data : hold;
    miss      = scan_enable && tick && p_win && pending && !fb_read_valid;
  end

  // Timing counters, fetch issue, read capture and registered video outputs.
  always_ff @(posedge clk) begin
    if (rst || !scan_enable) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      p_active    <= 1'b0;
      p_hs        <= 1'b0;
      p_vs        <= 1'b0;
      p_win       <= 1'b0;
      p_origin    <= 1'b0;
      pending     <= 1'b0;
      hold        <= '0;
      fb_read_en  <= 1'b0;
      fb_read_x   <= '0;
      fb_read_y   <= '0;
      vid_rgb     <= '0;
      vid_de      <= 1'b0;
      vid_hsync   <= ~SYNC_POL;
      vid_vsync   <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      fb_read_en  <= 1'b0;
      frame_start <= 1'b0;
      div_cnt     <= (32'(div_cnt) == CLK_DIV - 1) ? '0 : div_cnt + DW'(1);
      if (pending && fb_read_valid) begin
        hold    <= fb_read_data;
        pending <= 1'b0;
      end
      if (tick) begin
        if (hu == H_TOTAL - 1) begin
          h_cnt <= '0;
          v_cnt <= (vu == V_TOTAL - 1) ? '0 : v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
        vid_de      <= p_active;
        vid_rgb     <= p_win ? pix : (p_active ? border_color : '0);
        vid_hsync   <= p_hs ? SYNC_POL : ~SYNC_POL;
        vid_vsync   <= p_vs ? SYNC_POL : ~SYNC_POL;
        frame_start <= p_origin;
        p_active    <= active;
        p_hs        <= hs_on;
        p_vs        <= vs_on;
        p_win       <= in_win;
        p_origin    <= at_origin;
        pending     <= in_win;
        hold        <= '0;
        if (in_win) begin
          fb_read_en <= 1'b1;
          fb_read_x  <= XW'(dx >> SCALE_LOG2);
          fb_read_y  <= YW'(dy >> SCALE_LOG2);
        end
      end
    end
  end

  // Sticky underrun flag; a miss in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (miss) begin
      underrun <= 1'b1;
    end else if (underrun_clear) begin
      underrun <= 1'b0;
    end
  end

endmodule
